jalapeno_sequencer: RTL and testbench
=====================================

Name: jalapeno_sequencer

Overview:
- Fetch/sequencing front end of the 4-bit Jalapeño processor.
- Holds the program counter, the fetch register, the phase flip-flop and the C/Z flag register.
- Produces the 7-bit microcode address {instr, C, Z, phase} that drives the microcode decoder ROM.
- Consumes the 13-bit control word the ROM returns and applies its PC and flag fields, closing the control loop.

Parameters:
- PC_W, 12, program counter width (jump target = {oprnd, next byte} = 4+8 bits).
- RST_PC, 12'h000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  clock enable / single-step; 0 = hold all state
- prog_byte  in  8  program memory data at address pc (combinational, same cycle)
- ctrl  in  13  control word from microcode ROM; [12]=incPC, [11]=loadPC, [10]=loadA, [9]=loadFlags, [8:6]=ALU sel, [5]=csRAM, [4]=weRAM, [3]=oeALU, [2]=oeIN, [1]=oeOprnd, [0]=loadOut
- alu_c  in  1  ALU carry result
- alu_z  in  1  ALU zero result
- pc  out  PC_W  program counter / program memory address
- rom_addr  out  7  {instr[3:0], flag_c, flag_z, phase} to microcode ROM
- instr  out  4  latched opcode nibble
- oprnd  out  4  latched operand nibble
- phase  out  1  0 = fetch, 1 = execute
- flag_c  out  1  registered carry flag
- flag_z  out  1  registered zero flag

Behaviour:
- Reset (asynchronous, reset_n low): pc=RST_PC, phase=0, instr=0, oprnd=0, flag_c=0, flag_z=0. Outputs are valid immediately; no clock is needed.
- Deassertion: the first enabled rising edge after reset_n rises performs a fetch.
- All state updates occur only on a rising clk edge with enable=1. With enable=0, every register holds.
- rom_addr is purely combinational from the registers: rom_addr = {instr, flag_c, flag_z, phase}. Latency from ctrl to state change is 1 edge.
- Phase: toggles 0->1->0 on every enabled edge. Two cycles per instruction.
- Fetch register: loads instr=prog_byte[7:4] and oprnd=prog_byte[3:0] on an enabled edge only when phase=0. It holds during phase 1.
- PC update, every enabled edge, priority order:
  - loadPC=1: pc <= {oprnd, prog_byte}. The target's high nibble comes from the current oprnd register; the low byte is the program byte at the current pc.
  - else incPC=1: pc <= pc+1, modulo 2^PC_W (12'hFFF wraps to 12'h000).
  - else: hold.
- incPC and loadPC both 1: loadPC wins.
- loadPC during phase 0: uses the oprnd register value before this edge's fetch latch (old value). This is legal but the microcode does not issue it.
- Flags: when loadFlags=1 on an enabled edge, flag_c <= alu_c and flag_z <= alu_z. Otherwise they hold.
- The flag update is visible in rom_addr of the next instruction, so a conditional jump samples flags from a prior instruction.
- Bits [8:0] and [10] of ctrl are not consumed here; they go to the datapath directly.
- Mid-operation reset_n assertion forces the reset state regardless of phase. A partially executed instruction is discarded.
- ctrl containing X/Z: no requirement. The bench drives only legal ROM outputs.

Test Plan:
- Reset: assert reset_n=0 mid-phase-1 with pc=12'h3A5 -> pc=000, phase=0, rom_addr=7'b0000000 within the same cycle, no clock edge required.
- Fetch/increment: prog_byte=8'h2B, ctrl incPC only, 2 enabled edges -> instr=2, oprnd=B, pc=002, phase=0, rom_addr after first edge=7'b0010001.
- Taken jump: fetch 8'h05 at pc 010, next byte 8'h7C, ctrl loadPC|incPC in phase 1 -> pc=57C (loadPC priority).
- Flags: ctrl loadFlags with alu_c=1, alu_z=0 in phase 1, then fetch opcode 0000 -> rom_addr=7'b0000101; with loadFlags=0 the flags hold across 4 instructions.
- Wrap/enable: pc=FFF, incPC -> pc=000; enable=0 for 5 cycles with ctrl=incPC -> pc, phase, instr and flags unchanged.

Source files
------------

// File: rtl/jalapeno_sequencer_if.sv
// Bus between the Jalapeno sequencer and its surroundings: program memory,
// microcode ROM, ALU flag results and the single-step enable.
interface jalapeno_sequencer_if #(
  parameter int PC_W = 12
);
  logic            enable;
  logic [7:0]      prog_byte;
  logic [12:0]     ctrl;
  logic            alu_c;
  logic            alu_z;
  logic [PC_W-1:0] pc;
  logic [6:0]      rom_addr;
  logic [3:0]      instr;
  logic [3:0]      oprnd;
  logic            phase;
  logic            flag_c;
  logic            flag_z;

  modport master (
    output enable, prog_byte, ctrl, alu_c, alu_z,
    input  pc, rom_addr, instr, oprnd, phase, flag_c, flag_z
  );

  modport slave (
    input  enable, prog_byte, ctrl, alu_c, alu_z,
    output pc, rom_addr, instr, oprnd, phase, flag_c, flag_z
  );
endinterface

// File: rtl/jalapeno_sequencer.sv
// Fetch/sequencing front end of the 4-bit Jalapeno processor: PC, fetch
// register, fetch/execute phase and C/Z flags, driven by the microcode word.
module jalapeno_sequencer #(
  parameter int              PC_W   = 12,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  jalapeno_sequencer_if.slave  bus
);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

  phase_t          phase_reg, phase_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [3:0]      instr_reg, instr_next;
  logic [3:0]      oprnd_reg, oprnd_next;
  logic            flag_c_reg, flag_c_next;
  logic            flag_z_reg, flag_z_next;

  logic inc_pc, load_pc, load_flags;
  assign inc_pc     = bus.ctrl[12];
  assign load_pc    = bus.ctrl[11];
  assign load_flags = bus.ctrl[9];

  // The remaining control bits feed the datapath directly.
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, bus.ctrl[10], bus.ctrl[8:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_reg  <= PH_FETCH;
      pc_reg     <= RST_PC;
      instr_reg  <= 4'h0;
      oprnd_reg  <= 4'h0;
      flag_c_reg <= 1'b0;
      flag_z_reg <= 1'b0;
    end else if (bus.enable) begin
      phase_reg  <= phase_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      oprnd_reg  <= oprnd_next;
      flag_c_reg <= flag_c_next;
      flag_z_reg <= flag_z_next;
    end
  end

  always_comb begin
    phase_next  = phase_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    oprnd_next  = oprnd_reg;
    flag_c_next = flag_c_reg;
    flag_z_next = flag_z_reg;

    unique case (phase_reg)
      PH_FETCH: begin
        phase_next = PH_EXEC;
        instr_next = bus.prog_byte[7:4];
        oprnd_next = bus.prog_byte[3:0];
      end
      PH_EXEC: phase_next = PH_FETCH;
      default: phase_next = PH_FETCH;
    endcase

    // Jump target high nibble is the oprnd held before this edge's fetch.
    if (load_pc) begin
      pc_next = PC_W'({oprnd_reg, bus.prog_byte});
    end else if (inc_pc) begin
      pc_next = pc_reg + PC_W'(1);
    end

    if (load_flags) begin
      flag_c_next = bus.alu_c;
      flag_z_next = bus.alu_z;
    end
  end

  assign bus.pc       = pc_reg;
  assign bus.instr    = instr_reg;
  assign bus.oprnd    = oprnd_reg;
  assign bus.phase    = phase_reg;
  assign bus.flag_c   = flag_c_reg;
  assign bus.flag_z   = flag_z_reg;
  assign bus.rom_addr = {instr_reg, flag_c_reg, flag_z_reg, phase_reg};

endmodule

// File: tb/tb_jalapeno_sequencer.sv
// Directed-vector bench for jalapeno_sequencer; expected values are hand-computed.
module tb_jalapeno_sequencer;

  localparam logic [12:0] C_INC  = 13'h1000;
  localparam logic [12:0] C_LDPC = 13'h0800;
  localparam logic [12:0] C_LDF  = 13'h0200;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  jalapeno_sequencer_if #(.PC_W(12)) bus ();

  jalapeno_sequencer #(.PC_W(12), .RST_PC(12'h000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // One clock edge, then settle 1ns before inputs are changed or outputs read.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("edge t=%0t en=%b pb=%h ctrl=%h -> pc=%h ph=%b instr=%h oprnd=%h c=%b z=%b rom=%b",
             $time, bus.enable, bus.prog_byte, bus.ctrl, bus.pc, bus.phase,
             bus.instr, bus.oprnd, bus.flag_c, bus.flag_z, bus.rom_addr);
  endtask

  task automatic drive(input logic [7:0] pb, input logic [12:0] c,
                       input logic ac, input logic az);
    bus.prog_byte = pb;
    bus.ctrl      = c;
    bus.alu_c     = ac;
    bus.alu_z     = az;
  endtask

  task automatic test_power_on();
    vectors++;
    if (bus.pc !== 12'h000) begin
      miscompares++;
      $display("FAIL power_on_pc: got %h want 000", bus.pc);
    end
    vectors++;
    if (bus.rom_addr !== 7'b0000000 || bus.phase !== 1'b0) begin
      miscompares++;
      $display("FAIL power_on_rom: got rom=%b ph=%b want 0000000/0", bus.rom_addr, bus.phase);
    end
  endtask

  task automatic test_fetch_inc();
    bus.enable = 1'b1;
    drive(8'h2B, C_INC, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.rom_addr !== 7'b0010001) begin
      miscompares++;
      $display("FAIL fetch_rom1: got %b want 0010001", bus.rom_addr);
    end
    vectors++;
    if (bus.pc !== 12'h001) begin
      miscompares++;
      $display("FAIL fetch_pc1: got %h want 001", bus.pc);
    end
    drive(8'h00, C_INC, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.instr !== 4'h2 || bus.oprnd !== 4'hB) begin
      miscompares++;
      $display("FAIL fetch_hold: got instr=%h oprnd=%h want 2/B", bus.instr, bus.oprnd);
    end
    vectors++;
    if (bus.pc !== 12'h002 || bus.phase !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_pc2: got pc=%h ph=%b want 002/0", bus.pc, bus.phase);
    end
  endtask

  task automatic test_jump();
    drive(8'h00, C_INC, 1'b0, 1'b0);   // fetch, oprnd=0
    tick();
    drive(8'h10, C_LDPC, 1'b0, 1'b0);  // jump to 010
    tick();
    vectors++;
    if (bus.pc !== 12'h010) begin
      miscompares++;
      $display("FAIL jump_setup: got %h want 010", bus.pc);
    end
    drive(8'h05, C_INC, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.oprnd !== 4'h5 || bus.pc !== 12'h011) begin
      miscompares++;
      $display("FAIL jump_fetch: got oprnd=%h pc=%h want 5/011", bus.oprnd, bus.pc);
    end
    drive(8'h7C, C_LDPC | C_INC, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.pc !== 12'h57C) begin
      miscompares++;
      $display("FAIL jump_taken: got %h want 57C", bus.pc);
    end
  endtask

  task automatic test_reset();
    drive(8'h03, C_INC, 1'b0, 1'b0);
    tick();
    drive(8'hA5, C_LDPC, 1'b0, 1'b0);
    tick();
    drive(8'h9F, C_LDF, 1'b1, 1'b1);   // fetch with pc hold, set both flags
    tick();
    drive(8'h9F, C_LDF, 1'b1, 1'b1);
    tick();
    drive(8'h9F, 13'h0000, 1'b1, 1'b1);
    tick();
    vectors++;
    if (bus.pc !== 12'h3A5 || bus.phase !== 1'b1 || bus.flag_c !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_setup: got pc=%h ph=%b c=%b want 3A5/1/1", bus.pc, bus.phase, bus.flag_c);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.pc !== 12'h000 || bus.phase !== 1'b0 || bus.rom_addr !== 7'b0000000) begin
      miscompares++;
      $display("FAIL reset_async: got pc=%h ph=%b rom=%b want 000/0/0000000",
               bus.pc, bus.phase, bus.rom_addr);
    end
    vectors++;
    if (bus.oprnd !== 4'h0 || bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs: got oprnd=%h c=%b z=%b want 0/0/0", bus.oprnd, bus.flag_c, bus.flag_z);
    end
    drive(8'hC7, C_INC | C_LDF, 1'b1, 1'b1);
    tick();
    vectors++;
    if (bus.pc !== 12'h000 || bus.instr !== 4'h0 || bus.flag_z !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got pc=%h instr=%h z=%b want 000/0/0", bus.pc, bus.instr, bus.flag_z);
    end
    reset_n = 1'b1;
    drive(8'hC7, C_INC, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.instr !== 4'hC || bus.oprnd !== 4'h7 || bus.pc !== 12'h001 || bus.phase !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_fetch: got instr=%h oprnd=%h pc=%h ph=%b want C/7/001/1",
               bus.instr, bus.oprnd, bus.pc, bus.phase);
    end
    drive(8'h00, 13'h0000, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_flags();
    drive(8'h40, C_INC, 1'b0, 1'b0);
    tick();
    drive(8'h00, C_INC | C_LDF, 1'b1, 1'b0);
    tick();
    vectors++;
    if (bus.rom_addr !== 7'b0100100) begin
      miscompares++;
      $display("FAIL flags_load: got rom=%b want 0100100", bus.rom_addr);
    end
    drive(8'h00, C_INC, 1'b0, 1'b1);
    tick();
    vectors++;
    if (bus.rom_addr !== 7'b0000101) begin
      miscompares++;
      $display("FAIL flags_rom: got %b want 0000101", bus.rom_addr);
    end
    for (int i = 0; i < 4; i++) begin
      drive(8'h00, C_INC, i[0], ~i[0]);
      tick();
      drive(8'h10 * (i + 1), C_INC, ~i[0], i[0]);
      tick();
      vectors++;
      if (bus.flag_c !== 1'b1 || bus.flag_z !== 1'b0) begin
        miscompares++;
        $display("FAIL flags_hold%0d: got c=%b z=%b want 1/0", i, bus.flag_c, bus.flag_z);
      end
    end
    drive(8'h00, C_INC, 1'b0, 1'b0);
    tick();
    drive(8'hF0, C_INC, 1'b1, 1'b1);
    tick();
    drive(8'h00, C_INC | C_LDF, 1'b0, 1'b1);
    tick();
    drive(8'hF3, C_INC, 1'b1, 1'b0);
    tick();
    vectors++;
    if (bus.rom_addr !== 7'b1111011) begin
      miscompares++;
      $display("FAIL flags_rom2: got %b want 1111011", bus.rom_addr);
    end
    drive(8'h00, C_INC, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_wrap_enable();
    drive(8'h0F, C_INC, 1'b0, 1'b0);
    tick();
    drive(8'hFF, C_LDPC, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.pc !== 12'hFFF) begin
      miscompares++;
      $display("FAIL wrap_setup: got %h want FFF", bus.pc);
    end
    drive(8'hA1, C_INC, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.pc !== 12'h000 || bus.instr !== 4'hA) begin
      miscompares++;
      $display("FAIL wrap_pc: got pc=%h instr=%h want 000/A", bus.pc, bus.instr);
    end
    bus.enable = 1'b0;
    drive(8'h5E, C_INC | C_LDPC | C_LDF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (bus.pc !== 12'h000 || bus.phase !== 1'b1 || bus.instr !== 4'hA ||
          bus.oprnd !== 4'h1 || bus.flag_c !== 1'b0 || bus.flag_z !== 1'b1) begin
        miscompares++;
        $display("FAIL enable_hold%0d: got pc=%h ph=%b instr=%h oprnd=%h c=%b z=%b want 000/1/A/1/0/1",
                 i, bus.pc, bus.phase, bus.instr, bus.oprnd, bus.flag_c, bus.flag_z);
      end
    end
    bus.enable = 1'b1;
    drive(8'h5E, C_INC, 1'b1, 1'b0);
    tick();
    vectors++;
    if (bus.pc !== 12'h001 || bus.phase !== 1'b0 || bus.instr !== 4'hA) begin
      miscompares++;
      $display("FAIL enable_resume: got pc=%h ph=%b instr=%h want 001/0/A", bus.pc, bus.phase, bus.instr);
    end
  endtask

  task automatic test_back_to_back();
    // loadPC during fetch uses oprnd from before this edge (1), not the new 2.
    drive(8'h72, C_LDPC, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.pc !== 12'h172 || bus.instr !== 4'h7 || bus.oprnd !== 4'h2) begin
      miscompares++;
      $display("FAIL ldpc_fetch: got pc=%h instr=%h oprnd=%h want 172/7/2", bus.pc, bus.instr, bus.oprnd);
    end
    drive(8'h33, 13'h0000, 1'b0, 1'b0);
    tick();
    vectors++;
    if (bus.pc !== 12'h172 || bus.phase !== 1'b0 || bus.rom_addr !== 7'b0111010) begin
      miscompares++;
      $display("FAIL pc_hold: got pc=%h ph=%b rom=%b want 172/0/0111010", bus.pc, bus.phase, bus.rom_addr);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.enable = 1'b0;
    drive(8'h00, 13'h0000, 1'b0, 1'b0);
    #2;
    test_power_on();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_fetch_inc();
    test_jump();
    test_reset();
    test_flags();
    test_wrap_enable();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
